// File: rtl/vec_pkg.sv
// vec_pkg: shared definitions for the vector execution core.
//   Op encodings, FSM state enum, default geometry and derived widths,
//   plus an op legality helper.
package vec_pkg;

   // Command opcodes
   localparam logic [2:0] OP_VADD = 3'b000;
   localparam logic [2:0] OP_VMUL = 3'b001;
   localparam logic [2:0] OP_VST  = 3'b010;
   localparam logic [2:0] OP_VLD  = 3'b011;
   localparam logic [2:0] OP_NOP  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_ST,
      S_LD,
      S_RESP
   } state_t;

   // Default geometry
   localparam int unsigned LANES_DFLT     = 16;
   localparam int unsigned EW_DFLT        = 32;
   localparam int unsigned ALU_LANES_DFLT = 4;
   localparam int unsigned NREGS_DFLT     = 4;
   localparam int unsigned MEM_AW_DFLT    = 9;

   // Derived widths for the default geometry
   localparam int unsigned VW    = LANES_DFLT * EW_DFLT;
   localparam int unsigned BEATS = LANES_DFLT / ALU_LANES_DFLT;
   localparam int unsigned RAW   = $clog2(NREGS_DFLT);

   function automatic logic op_is_legal(input logic [2:0] op);
      return (op == OP_VADD) || (op == OP_VMUL) || (op == OP_VST) ||
             (op == OP_VLD)  || (op == OP_NOP);
   endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// vec_lane_alu: combinational ALU_LANES-wide add/multiply slice.
//   is_mul  in   1                 select unsigned multiply (else add)
//   a, b    in   ALU_LANES*EW      operand lanes, lane i at [i*EW +: EW]
//   res     out  ALU_LANES*2*EW    per lane {hi,lo}; add gives hi=0, lo=(a+b) mod 2^EW
module vec_lane_alu #(
   parameter int unsigned ALU_LANES = 4,
   parameter int unsigned EW        = 32
) (
   input  logic                      is_mul,
   input  logic [ALU_LANES*EW-1:0]   a,
   input  logic [ALU_LANES*EW-1:0]   b,
   output logic [2*ALU_LANES*EW-1:0] res
);

   for (genvar g = 0; g < ALU_LANES; g++) begin : g_lane
      logic [EW-1:0]   al;
      logic [EW-1:0]   bl;
      logic [EW-1:0]   sum;
      logic [2*EW-1:0] prod;

      assign al   = a[g*EW +: EW];
      assign bl   = b[g*EW +: EW];
      assign sum  = al + bl;
      assign prod = (2*EW)'(al) * (2*EW)'(bl);
      assign res[g*2*EW +: 2*EW] = is_mul ? prod : {{EW{1'b0}}, sum};
   end

endmodule

// File: rtl/vec_exec_unit.sv
// vec_exec_unit: parametrised vector execution core.
//   NREGS x (LANES*EW) register file; VADD/VMUL over ALU_LANES lanes per cycle;
//   VLD/VST as LANES-beat bursts to a 1-cycle-latency synchronous memory.
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready iff IDLE)
//   cmd_op/rd/rs1/rs2/addr   command payload
//   done, err                completion pulse, illegal-op pulse
//   mem_addr/we/wdata/rdata  external memory port
//   dbg_raddr/dbg_rdata      combinational register file peek
module vec_exec_unit
   import vec_pkg::*;
#(
   parameter  int unsigned LANES     = LANES_DFLT,
   parameter  int unsigned EW        = EW_DFLT,
   parameter  int unsigned ALU_LANES = ALU_LANES_DFLT,
   parameter  int unsigned NREGS     = NREGS_DFLT,
   parameter  int unsigned MEM_AW    = MEM_AW_DFLT,
   localparam int unsigned RA_W      = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [RA_W-1:0]       cmd_rd,
   input  logic [RA_W-1:0]       cmd_rs1,
   input  logic [RA_W-1:0]       cmd_rs2,
   input  logic [MEM_AW-1:0]     cmd_addr,
   output logic                  done,
   output logic                  err,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic                  mem_we,
   output logic [EW-1:0]         mem_wdata,
   input  logic [EW-1:0]         mem_rdata,
   input  logic [RA_W-1:0]       dbg_raddr,
   output logic [LANES*EW-1:0]   dbg_rdata
);

   localparam int unsigned VEC_W   = LANES * EW;
   localparam int unsigned N_BEATS = LANES / ALU_LANES;
   localparam int unsigned SL_W    = ALU_LANES * EW;
   localparam int unsigned BT_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
   localparam int unsigned LN_W    = $clog2(LANES);
   localparam int unsigned CN_W    = $clog2(LANES + 2);

   // Geometry sanity
   if ((LANES % ALU_LANES) != 0) begin : g_bad_lanes
      $error("vec_exec_unit: LANES must be a multiple of ALU_LANES");
   end
   if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
      $error("vec_exec_unit: NREGS must be a power of 2 and >= 2");
   end

   state_t              state_q, state_d;
   logic [CN_W-1:0]     cnt_q, cnt_d;
   logic [2:0]          op_q;
   logic [RA_W-1:0]     rd_q;
   logic [MEM_AW-1:0]   addr_q;
   logic [VEC_W-1:0]    a_q, b_q;
   logic [VEC_W-1:0]    stage_lo_q, stage_hi_q, stage_lo_d, stage_hi_d;
   logic [VEC_W-1:0]    rf [NREGS];

   logic                accept;
   logic                commit_lo, commit_hi;
   logic                done_d, err_d, mem_we_d;
   logic [MEM_AW-1:0]   mem_addr_d;
   logic [EW-1:0]       mem_wdata_d;

   logic [SL_W-1:0]     a_beats [N_BEATS];
   logic [SL_W-1:0]     b_beats [N_BEATS];
   logic [SL_W-1:0]     a_sl, b_sl, lo_sl, hi_sl;
   logic [2*SL_W-1:0]   alu_res;
   logic [BT_W-1:0]     beat;
   logic [LN_W-1:0]     st_lane, ld_lane;
   logic [EW-1:0]       st_word;

   assign cmd_ready = (state_q == S_IDLE);
   assign accept    = cmd_valid && (state_q == S_IDLE);
   assign dbg_rdata = rf[dbg_raddr];

   // Operand slices for the current EXEC beat, taken from the snapshots
   for (genvar g = 0; g < N_BEATS; g++) begin : g_beat
      assign a_beats[g] = a_q[g*SL_W +: SL_W];
      assign b_beats[g] = b_q[g*SL_W +: SL_W];
   end

   assign beat = BT_W'(cnt_q);
   assign a_sl = a_beats[beat];
   assign b_sl = b_beats[beat];

   vec_lane_alu #(
      .ALU_LANES (ALU_LANES),
      .EW        (EW)
   ) u_alu (
      .is_mul (op_q == OP_VMUL),
      .a      (a_sl),
      .b      (b_sl),
      .res    (alu_res)
   );

   // Split per-lane {hi,lo} into separate low/high slices
   for (genvar g = 0; g < ALU_LANES; g++) begin : g_split
      assign lo_sl[g*EW +: EW] = alu_res[g*2*EW      +: EW];
      assign hi_sl[g*EW +: EW] = alu_res[g*2*EW + EW +: EW];
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stage_lo_d  = stage_lo_q;
      stage_hi_d  = stage_hi_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      commit_lo   = 1'b0;
      commit_hi   = 1'b0;

      // Store beat cnt+1 sends lane LANES-2-cnt; load capture at cnt fills lane LANES-cnt
      st_lane = LN_W'(LANES - 2) - LN_W'(cnt_q);
      ld_lane = LN_W'(CN_W'(LANES) - cnt_q);
      st_word = '0;
      for (int l = 0; l < int'(LANES); l++) begin
         if (LN_W'(l) == st_lane) st_word = a_q[l*EW +: EW];
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d = '0;
               case (cmd_op)
                  OP_VADD, OP_VMUL: state_d = S_EXEC;
                  OP_VST: begin
                     // Beat 0 goes out straight from the register file
                     state_d     = S_ST;
                     mem_we_d    = 1'b1;
                     mem_addr_d  = cmd_addr;
                     mem_wdata_d = rf[cmd_rs1][VEC_W-1 -: EW];
                  end
                  OP_VLD: begin
                     state_d    = S_LD;
                     mem_addr_d = cmd_addr;
                  end
                  default: state_d = S_RESP;
               endcase
            end
         end

         S_EXEC: begin
            for (int b = 0; b < int'(N_BEATS); b++) begin
               if (beat == BT_W'(b)) begin
                  stage_lo_d[b*SL_W +: SL_W] = lo_sl;
                  stage_hi_d[b*SL_W +: SL_W] = hi_sl;
               end
            end
            if (cnt_q == CN_W'(N_BEATS - 1)) begin
               commit_lo = 1'b1;
               commit_hi = (op_q == OP_VMUL);
               done_d    = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + CN_W'(1);
            end
         end

         S_ST: begin
            if (cnt_q == CN_W'(LANES - 1)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q + MEM_AW'(cnt_q) + MEM_AW'(1);
               mem_wdata_d = st_word;
               cnt_d       = cnt_q + CN_W'(1);
            end
         end

         S_LD: begin
            // Read data lags the issued address by two edges
            if (cnt_q >= CN_W'(1)) begin
               for (int l = 0; l < int'(LANES); l++) begin
                  if (LN_W'(l) == ld_lane) stage_lo_d[l*EW +: EW] = mem_rdata;
               end
            end
            if (cnt_q <= CN_W'(LANES - 2)) begin
               mem_addr_d = addr_q + MEM_AW'(cnt_q) + MEM_AW'(1);
            end
            if (cnt_q == CN_W'(LANES)) begin
               commit_lo = 1'b1;
               done_d    = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + CN_W'(1);
            end
         end

         S_RESP: begin
            done_d  = 1'b1;
            err_d   = !op_is_legal(op_q);
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Datapath, registered outputs and register file
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         op_q       <= '0;
         rd_q       <= '0;
         addr_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         stage_lo_q <= '0;
         stage_hi_q <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         for (int r = 0; r < int'(NREGS); r++) rf[r] <= '0;
      end else begin
         cnt_q      <= cnt_d;
         stage_lo_q <= stage_lo_d;
         stage_hi_q <= stage_hi_d;
         done       <= done_d;
         err        <= err_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         // Snapshots make rd/rs aliasing and the VMUL high-half wrap safe
         if (accept) begin
            op_q   <= cmd_op;
            rd_q   <= cmd_rd;
            addr_q <= cmd_addr;
            a_q    <= rf[cmd_rs1];
            b_q    <= rf[cmd_rs2];
         end
         if (commit_lo) rf[rd_q]              <= stage_lo_d;
         if (commit_hi) rf[rd_q + RA_W'(1)]   <= stage_hi_d;
      end
   end

endmodule

// File: tb/tb_vec_exec_unit.sv
// tb_vec_exec_unit: directed self-checking bench for vec_exec_unit
// (16 lanes x 32b, 4 ALU lanes, 4 registers, 9-bit memory address)
// with a 1-cycle synchronous memory model.
module tb_vec_exec_unit;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [1:0]    cmd_rd, cmd_rs1, cmd_rs2;
   logic [8:0]    cmd_addr;
   logic          done, err;
   logic [8:0]    mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic [1:0]    dbg_raddr;
   logic [511:0]  dbg_rdata;

   logic [31:0]   mem [512];

   int            n_checks = 0;
   int            n_fail   = 0;

   // Per-command observation results
   int            lat, busy_ready, we_cnt;
   logic          err_seen;
   logic [8:0]    wr_addr [32];
   logic [31:0]   wr_data [32];

   // Reference register contents
   logic [511:0]  exp_r0, exp_r1, exp_r2, exp_r3, r1_orig;

   vec_exec_unit #(
      .LANES(16), .EW(32), .ALU_LANES(4), .NREGS(4), .MEM_AW(9)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_rd    (cmd_rd),
      .cmd_rs1   (cmd_rs1),
      .cmd_rs2   (cmd_rs2),
      .cmd_addr  (cmd_addr),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .dbg_raddr (dbg_raddr),
      .dbg_rdata (dbg_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lane value of the second preload vector: lanes 15..1 = 1111_1111 .. FFFF_FFFF, lane 0 = 0
   function automatic logic [31:0] r1_lane(input int l);
      logic [31:0] k;
      k = 32'(16 - l);
      return (l == 0) ? 32'h0 : k * 32'h1111_1111;
   endfunction

   // Preload: 0x000..0x00F = AAAAAAAA, 0x010..0x01F = r1 lanes MS first
   function automatic logic [31:0] mem_init(input int a);
      if (a < 16)      return 32'hAAAA_AAAA;
      else if (a < 32) return r1_lane(15 - (a - 16));
      else             return 32'h0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 512; i++) mem[i] <= mem_init(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   function automatic logic [31:0] lane(input logic [511:0] v, input int l);
      return v[l*32 +: 32];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_reg(input logic [1:0] r, output logic [511:0] v);
      dbg_raddr = r;
      #1;
      v = dbg_rdata;
   endtask

   // Issue one command and follow it to done within a 40-cycle budget
   task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [8:0] addr);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_rd    = rd;
      cmd_rs1   = rs1;
      cmd_rs2   = rs2;
      cmd_addr  = addr;
      step();
      cmd_valid  = 1'b0;
      lat        = -1;
      err_seen   = 1'b0;
      busy_ready = 0;
      we_cnt     = 0;
      for (int k = 1; k <= 40; k++) begin
         if (mem_we && we_cnt < 32) begin
            wr_addr[we_cnt] = mem_addr;
            wr_data[we_cnt] = mem_wdata;
            we_cnt++;
         end
         step();
         if (done) begin
            lat      = k;
            err_seen = err;
            break;
         end
         if (cmd_ready) busy_ready++;
      end
   endtask

   task automatic test_reset();
      logic [511:0] v;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b111;
      cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_addr = '0; dbg_raddr = '0;
      step(); step();
      rst = 1'b0;
      n_checks++;
      if ({cmd_ready, done, err, mem_we} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready/done/err/we got %b expected 1000", {cmd_ready, done, err, mem_we});
      end
      n_checks++;
      if ({mem_addr, mem_wdata} !== 41'h0) begin
         n_fail++;
         $display("FAIL reset_mem: addr %h wdata %h expected 0", mem_addr, mem_wdata);
      end
      for (int r = 0; r < 4; r++) begin
         rd_reg(2'(r), v);
         n_checks++;
         if (v !== 512'h0) begin
            n_fail++;
            $display("FAIL reset_rf%0d: got %h expected 0", r, v);
         end
      end
   endtask

   task automatic test_vld();
      logic [511:0] v;
      exp_r0 = {16{32'hAAAA_AAAA}};
      for (int l = 0; l < 16; l++) exp_r1[l*32 +: 32] = r1_lane(l);
      r1_orig = exp_r1;
      issue(3'b011, 2'd0, 2'd0, 2'd0, 9'h000);
      n_checks++;
      if (lat !== 17 || err_seen !== 1'b0 || busy_ready !== 0 || we_cnt !== 0) begin
         n_fail++;
         $display("FAIL vld_r0_timing: lat %0d err %b rdy %0d we %0d expected 17 0 0 0", lat, err_seen, busy_ready, we_cnt);
      end
      step();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: done got %b expected 0", done);
      end
      issue(3'b011, 2'd1, 2'd0, 2'd0, 9'h010);
      n_checks++;
      if (lat !== 17) begin
         n_fail++;
         $display("FAIL vld_r1_latency: got %0d expected 17", lat);
      end
      rd_reg(2'd0, v);
      n_checks++;
      if (v !== exp_r0) begin
         n_fail++;
         $display("FAIL vld_r0_data: got %h expected %h", v, exp_r0);
      end
      rd_reg(2'd1, v);
      n_checks++;
      if (v !== exp_r1) begin
         n_fail++;
         $display("FAIL vld_r1_data: got %h expected %h", v, exp_r1);
      end
   endtask

   task automatic test_vadd();
      logic [511:0] v;
      for (int l = 0; l < 16; l++) exp_r2[l*32 +: 32] = lane(exp_r0, l) + lane(exp_r1, l);
      issue(3'b000, 2'd2, 2'd0, 2'd1, 9'h000);
      n_checks++;
      if (lat !== 4 || err_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL vadd_latency: lat %0d err %b expected 4 0", lat, err_seen);
      end
      rd_reg(2'd2, v);
      n_checks++;
      if (lane(v, 15) !== 32'hBBBB_BBBB || lane(v, 1) !== 32'hAAAA_AAA9 || lane(v, 0) !== 32'hAAAA_AAAA) begin
         n_fail++;
         $display("FAIL vadd_lanes: l15 %h l1 %h l0 %h expected BBBBBBBB AAAAAAA9 AAAAAAAA", lane(v, 15), lane(v, 1), lane(v, 0));
      end
      n_checks++;
      if (v !== exp_r2) begin
         n_fail++;
         $display("FAIL vadd_vector: got %h expected %h", v, exp_r2);
      end
   endtask

   task automatic test_vmul();
      logic [511:0] v;
      logic [63:0]  p;
      logic [511:0] hi;
      for (int l = 0; l < 16; l++) begin
         p = 64'(lane(exp_r0, l)) * 64'(lane(exp_r1, l));
         exp_r3[l*32 +: 32] = p[31:0];
         hi[l*32 +: 32]     = p[63:32];
      end
      exp_r0 = hi;
      issue(3'b001, 2'd3, 2'd0, 2'd1, 9'h000);
      n_checks++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL vmul_latency: got %0d expected 4", lat);
      end
      rd_reg(2'd3, v);
      n_checks++;
      if (lane(v, 1) !== 32'h5555_5556 || lane(v, 0) !== 32'h0 || v !== exp_r3) begin
         n_fail++;
         $display("FAIL vmul_lo: l1 %h l0 %h expected 55555556 00000000", lane(v, 1), lane(v, 0));
      end
      rd_reg(2'd0, v);
      n_checks++;
      if (lane(v, 1) !== 32'hAAAA_AAA9 || lane(v, 0) !== 32'h0 || v !== exp_r0) begin
         n_fail++;
         $display("FAIL vmul_hi_wrap: l1 %h l0 %h expected AAAAAAA9 00000000", lane(v, 1), lane(v, 0));
      end
      rd_reg(2'd1, v);
      n_checks++;
      if (v !== exp_r1) begin
         n_fail++;
         $display("FAIL vmul_src_kept: got %h expected %h", v, exp_r1);
      end
   endtask

   task automatic test_vst_wrap();
      logic [511:0] v;
      issue(3'b010, 2'd0, 2'd2, 2'd0, 9'h1F8);
      n_checks++;
      if (lat !== 16 || we_cnt !== 16) begin
         n_fail++;
         $display("FAIL vst_timing: lat %0d we_cycles %0d expected 16 16", lat, we_cnt);
      end
      n_checks++;
      if (mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL vst_we_off: got %b expected 0", mem_we);
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (wr_addr[i] !== 9'(9'h1F8 + i) || wr_data[i] !== lane(exp_r2, 15 - i)) begin
            n_fail++;
            $display("FAIL vst_beat%0d: addr %h data %h expected %h %h", i, wr_addr[i], wr_data[i], 9'(9'h1F8 + i), lane(exp_r2, 15 - i));
         end
      end
      n_checks++;
      if (mem[9'h1F8] !== 32'hBBBB_BBBB || mem[9'h007] !== lane(exp_r2, 0)) begin
         n_fail++;
         $display("FAIL vst_mem: mem[1F8] %h mem[007] %h expected BBBBBBBB %h", mem[9'h1F8], mem[9'h007], lane(exp_r2, 0));
      end
      issue(3'b011, 2'd1, 2'd0, 2'd0, 9'h1F8);
      exp_r1 = exp_r2;
      rd_reg(2'd1, v);
      n_checks++;
      if (lat !== 17 || v !== exp_r2) begin
         n_fail++;
         $display("FAIL vld_wrap: lat %0d data %h expected 17 %h", lat, v, exp_r2);
      end
   endtask

   task automatic test_back_to_back();
      logic [511:0] v;
      int k1, k2, rdy_bad;
      logic rdy_at_done;
      cmd_valid = 1'b1; cmd_op = 3'b011; cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_addr = 9'h010;
      step();
      k1 = -1; rdy_bad = 0; rdy_at_done = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (done) begin k1 = k; rdy_at_done = cmd_ready; break; end
         if (cmd_ready) rdy_bad++;
      end
      n_checks++;
      if (k1 !== 17 || rdy_bad !== 0 || rdy_at_done !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_hold: done at %0d early_ready %0d ready_at_done %b expected 17 0 1", k1, rdy_bad, rdy_at_done);
      end
      // The held command is taken on the done-cycle edge
      step();
      cmd_valid = 1'b0;
      k2 = -1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (done) begin k2 = k; break; end
      end
      n_checks++;
      if (k2 !== 17) begin
         n_fail++;
         $display("FAIL b2b_accept: second done at %0d expected 17", k2);
      end
      exp_r0 = r1_orig;
      rd_reg(2'd0, v);
      n_checks++;
      if (v !== exp_r0) begin
         n_fail++;
         $display("FAIL b2b_data: got %h expected %h", v, exp_r0);
      end
   endtask

   task automatic test_illegal();
      logic [511:0] v0, v1, v2, v3;
      issue(3'b101, 2'd0, 2'd1, 2'd2, 9'h000);
      n_checks++;
      if (lat !== 1 || err_seen !== 1'b1) begin
         n_fail++;
         $display("FAIL illegal_op: lat %0d err %b expected 1 1", lat, err_seen);
      end
      rd_reg(2'd0, v0); rd_reg(2'd1, v1); rd_reg(2'd2, v2); rd_reg(2'd3, v3);
      n_checks++;
      if (v0 !== exp_r0 || v1 !== exp_r1 || v2 !== exp_r2 || v3 !== exp_r3) begin
         n_fail++;
         $display("FAIL illegal_rf: rf changed, r0 %h expected %h", v0, exp_r0);
      end
      issue(3'b111, 2'd0, 2'd0, 2'd0, 9'h000);
      n_checks++;
      if (lat !== 1 || err_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL nop: lat %0d err %b expected 1 0", lat, err_seen);
      end
      step();
      n_checks++;
      if (err !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pulse: done %b err %b expected 0 0", done, err);
      end
   endtask

   task automatic test_reset_mid();
      logic [511:0] v;
      int done_cnt;
      cmd_valid = 1'b1; cmd_op = 3'b010; cmd_rd = 2'd0; cmd_rs1 = 2'd2; cmd_rs2 = 2'd0; cmd_addr = 9'h040;
      step();
      cmd_valid = 1'b0;
      repeat (5) step();
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 9'h045) begin
         n_fail++;
         $display("FAIL vst_beat5: we %b addr %h expected 1 045", mem_we, mem_addr);
      end
      rst = 1'b1;
      step();
      n_checks++;
      if (mem_we !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_we: we %b done %b expected 0 0", mem_we, done);
      end
      rst = 1'b0;
      done_cnt = 0;
      repeat (20) begin
         step();
         if (done) done_cnt++;
      end
      n_checks++;
      if (done_cnt !== 0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_done: done pulses %0d ready %b expected 0 1", done_cnt, cmd_ready);
      end
      for (int r = 0; r < 4; r++) begin
         rd_reg(2'(r), v);
         n_checks++;
         if (v !== 512'h0) begin
            n_fail++;
            $display("FAIL abort_rf%0d: got %h expected 0", r, v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vld();
      test_vadd();
      test_vmul();
      test_vst_wrap();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
